// File: rtl/forward_ctrl_unit_if.sv
// Decode-stage request bundle and forwarding/stall responses of the forwarding control unit.
interface forward_ctrl_unit_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic [4:0]       id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_regwrite, id_memread, flush,
        input  fwd_a, fwd_b, stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_regwrite, id_memread, flush,
        output fwd_a, fwd_b, stall, stall_cnt
    );
endinterface

// File: rtl/forward_ctrl_unit.sv
// Forwarding select and load-use stall generation from a shadow EX/MEM/WB
// tracking pipeline that advances in lockstep with the datapath.
module forward_ctrl_unit #(
    parameter int CNT_W = 16
) (
    input logic                clk,
    input logic                rst,
    forward_ctrl_unit_if.slave bus
);
    logic             ex_valid_q, ex_rw_q, ex_mr_q;
    logic [4:0]       ex_dest_q;
    logic             mem_valid_q, mem_rw_q;
    logic [4:0]       mem_dest_q;
    logic             wb_valid_q, wb_rw_q;
    logic [4:0]       wb_dest_q;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             ex_src, mem_src, stall, enter;
    logic             unused_wb;

    // Nearest producer wins: the EX slot is younger than the MEM slot.
    function automatic logic [1:0] sel(input logic [4:0] s,
                                       input logic ex_ok, input logic [4:0] ex_d,
                                       input logic mem_ok, input logic [4:0] mem_d);
        if (s == 5'd0)                 return 2'd0;
        else if (ex_ok && ex_d == s)   return 2'd1;
        else if (mem_ok && mem_d == s) return 2'd2;
        else                           return 2'd0;
    endfunction

    always_comb begin
        ex_src  = ex_valid_q && ex_rw_q && (ex_dest_q != 5'd0);
        mem_src = mem_valid_q && mem_rw_q && (mem_dest_q != 5'd0);
        stall   = bus.id_valid && !bus.flush && ex_src && ex_mr_q &&
                  ((ex_dest_q == bus.id_rs) || (bus.id_uses_rt && (ex_dest_q == bus.id_rt)));
        enter   = bus.id_valid && !bus.flush && !stall;
        fwd_a_d = enter ? sel(bus.id_rs, ex_src, ex_dest_q, mem_src, mem_dest_q) : 2'd0;
        fwd_b_d = (enter && bus.id_uses_rt) ?
                  sel(bus.id_rt, ex_src, ex_dest_q, mem_src, mem_dest_q) : 2'd0;
        stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_rw_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            ex_dest_q   <= '0;
            mem_valid_q <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_dest_q  <= '0;
            wb_valid_q  <= 1'b0;
            wb_rw_q     <= 1'b0;
            wb_dest_q   <= '0;
            fwd_a_q     <= '0;
            fwd_b_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_valid_q  <= enter;
            ex_rw_q     <= enter && bus.id_regwrite;
            ex_mr_q     <= enter && bus.id_memread;
            ex_dest_q   <= bus.id_rd;
            mem_valid_q <= ex_valid_q;
            mem_rw_q    <= ex_rw_q;
            mem_dest_q  <= ex_dest_q;
            wb_valid_q  <= mem_valid_q;
            wb_rw_q     <= mem_rw_q;
            wb_dest_q   <= mem_dest_q;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // WB is tracked only; regfile write-through covers that hazard.
    assign unused_wb = ^{wb_valid_q, wb_rw_q, wb_dest_q};

    assign bus.fwd_a     = fwd_a_q;
    assign bus.fwd_b     = fwd_b_q;
    assign bus.stall     = stall;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: doc/forward_ctrl_unit.md
FORWARD_CTRL_UNIT -- requirements
Module: forward_ctrl_unit

Interface
REQ-001 Parameter CNT_W, default 16: width of the stall performance counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 id_valid  input  1  decode-stage instruction valid.
REQ-005 id_rs  input  5  decode-stage source register A.
REQ-006 id_rt  input  5  decode-stage source register B.
REQ-007 id_uses_rt  input  1  decode-stage instruction reads rt (R-type, store, branch).
REQ-008 id_rd  input  5  decode-stage destination register (rd or rt, already muxed).
REQ-009 id_regwrite  input  1  decode-stage instruction writes a register.
REQ-010 id_memread  input  1  decode-stage instruction is a load.
REQ-011 flush  input  1  branch/jump taken; kill decode-stage instruction.
REQ-012 fwd_a  output  2  operand-A select for the EX-stage 3:1 mux (0 regfile/ID-EX, 1 EX/MEM result, 2 MEM/WB result; 3 never driven).
REQ-013 fwd_b  output  2  operand-B select, same encoding.
REQ-014 stall  output  1  load-use stall: hold PC and IF/ID, insert bubble.
REQ-015 stall_cnt  output  CNT_W  saturating count of stall cycles.

Function
REQ-016 Internal tracking pipeline of three stages SHALL mirror the datapath: EX slot (valid, dest, regwrite, memread), MEM slot (valid, dest, regwrite), WB slot (valid, dest, regwrite); all advance every cycle.
REQ-017 Advance per cycle: WB <= MEM; MEM <= EX; EX <= decode instruction, or bubble (valid=0, regwrite=0, memread=0) when stall, flush or !id_valid.
REQ-018 A slot is a forwarding source only if valid, regwrite=1 and dest != 0.
REQ-019 fwd_a/fwd_b SHALL be registered: computed at the edge the decode instruction enters EX, valid for that instruction's full EX cycle.
REQ-020 Select rule for source s: 1 if current EX slot is a source with dest==s; else 2 if current MEM slot is a source with dest==s; else 0 (nearest producer wins).
REQ-021 fwd_b SHALL be 0 when id_uses_rt=0; both selects SHALL be 0 for s==0 and when a bubble enters EX.
REQ-022 stall SHALL be combinational: 1 iff id_valid, !flush, EX slot valid with memread=1, regwrite=1, dest!=0, and (dest==id_rs or (id_uses_rt and dest==id_rt)).
REQ-023 Stall duration is exactly one cycle per load-use pair; next cycle the load sits in MEM, stall deasserts, dependent instruction enters EX with select 2.
REQ-024 flush has priority over stall: flush=1 forces stall=0 and a bubble into EX.
REQ-025 stall_cnt SHALL increment by 1 each cycle stall=1 and saturate at 2^CNT_W-1 (no wrap).
REQ-026 WB slot is tracking-only; same-cycle regfile write-through is the register file's responsibility, not a select value.

Reset
REQ-027 On rst=1 at a rising edge: all slot valid/regwrite/memread bits 0, fwd_a=0, fwd_b=0, stall_cnt=0.
REQ-028 stall SHALL read 0 in the cycle after reset regardless of decode inputs (EX slot empty).
REQ-029 Reset mid-stall discards all tracked instructions; no forwarding select from pre-reset producers after reset.

Verification
REQ-030 ADD r3 then SUB r4,r3,r5 back-to-back -> SUB's EX cycle fwd_a=1, fwd_b=0, stall=0.
REQ-031 ADD r3, NOP, OR r6,r1,r3 -> OR's EX cycle fwd_a=0, fwd_b=2.
REQ-032 ADD r3 then ADD r3 then AND r7,r3,r3 -> AND's EX cycle fwd_a=1, fwd_b=1 (nearest wins).
REQ-033 LW r2 then ADD r4,r2,r1 -> stall=1 one cycle, stall_cnt 0->1, ADD's EX cycle fwd_a=2.
REQ-034 LW r2 followed by dependent with flush=1 same cycle -> stall=0, bubble in EX, stall_cnt unchanged; writes to r0 never forward (selects 0).
REQ-035 Force stall_cnt to saturate with CNT_W=2 over 5 stall cycles -> holds 3; rst=1 mid-stall -> next cycle all outputs 0.
